pipeline_mw_skid: RTL and testbench
===================================

// Module: pipeline_mw_skid
// PURPOSE
// - Parametrised MEM/WB stage register for the elastic pipeline. Carries writeback control and data from the memory stage to the writeback stage.
// - Adds a valid/ready handshake, a 2-entry skid buffer, a synchronous flush, and a sticky halt latch.
// - Sits between the memory stage (upstream) and the register-file writeback (downstream).
// PARAMETERS
// - DATA_W  16  width of ALU result and memory read data
// - SEL_W    3  width of destination register select
// PORTS
// - clk         in   1       clock; all state updates on the rising edge
// - rst         in   1       asynchronous, active-low reset
// - in_valid    in   1       upstream entry valid
// - in_ready    out  1       stage can accept an entry this cycle
// - in_wr_en    in   1       register-file write enable
// - in_mem_rd   in   1       1 = write back memory data, 0 = write back ALU data
// - in_halt     in   1       entry is a HALT
// - in_wr_sel   in   SEL_W   destination register
// - in_alu      in   DATA_W  ALU result
// - in_mem      in   DATA_W  memory read data
// - flush       in   1       discard all held entries
// - out_valid   out  1       head entry valid
// - out_ready   in   1       downstream consumes the head entry
// - out_wr_en, out_mem_rd, out_halt, out_wr_sel, out_alu, out_mem   out   head entry fields
// - wb_data     out  DATA_W  selected writeback value (see CONFIGURATION)
// - occupancy   out  2       number of held entries, 0..2
// - halt_done   out  1       a HALT has been delivered downstream (sticky)
// BEHAVIOUR
// - Storage: main register (head) plus skid register, each with its own valid bit.
// - Transfer rules:
//   - Input transfer: in_valid & in_ready.
//   - Output transfer: out_valid & out_ready.
// - Reset (rst=0, asynchronous):
//   - Both valid bits = 0; halt_done = 0.
//   - All payload registers = 0, so every out_* field = 0 and wb_data = 0.
//   - occupancy = 0, out_valid = 0.
// - Ready/valid/occupancy:
//   - in_ready = ~skid_valid & ~halt_done. It is registered, not dependent on out_ready.
//   - out_valid = main_valid & ~halt_done. occupancy = main_valid + skid_valid.
// - Latency and throughput: with the stage empty, an entry accepted at edge N is at the output after edge N. Sustained rate is 1 entry/cycle while out_ready = 1.
// - Next-state per edge:
//   - Main empty, input transfer: entry -> main.
//   - Main full, output transfer, no input transfer: skid -> main if skid is valid, otherwise main empties.
//   - Main full, output transfer and input transfer: skid -> main and input -> skid if skid is valid, otherwise input -> main.
//   - Main full, no output transfer, input transfer: input -> skid.
//   - Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
// - Flush (synchronous):
//   - At the edge, both valid bits clear and any input transfer in the same cycle is discarded.
//   - Payload registers keep their values.
//   - flush has priority over every transfer. An output transfer in the flush cycle still completes downstream.
// - Halt:
//   - An output transfer with out_halt = 1 sets halt_done at that edge.
//   - From then on, in_ready = 0 and out_valid = 0 until reset; flush does not clear halt_done.
//   - A HALT removed by flush never sets halt_done.
// - Boundary conditions:
//   - occupancy = 2 implies in_ready = 0.
//   - Asserting in_valid while in_ready = 0 has no effect; upstream must hold the entry.
//   - Reset asserted mid-stream drops all held entries immediately.
// CONFIGURATION
// - Macro PIPELINE_MW_WBMUX_EN:
//   - Defined: wb_data = out_mem_rd ? out_mem : out_alu. This is combinational from the head register, so no extra latency.
//   - Undefined: wb_data is tied to 0 and writeback selects from out_alu/out_mem itself.
//   - All other behaviour is identical in both builds.
// TESTING
// - Reset: rst=0 mid-traffic -> next cycle out_valid=0, occupancy=0, in_ready=1, halt_done=0, out_alu=16'h0000.
// - Streaming: 8 entries back-to-back (alu=1..8), out_ready=1 -> each appears 1 cycle after acceptance, in order, occupancy stays 1.
// - Backpressure: out_ready=0, send A then B -> occupancy=2, in_ready=0. Then out_ready=1 -> A then B delivered, in_ready=1 the cycle after A leaves.
// - Flush: occupancy=2, flush=1 with in_valid=1 (entry C) -> next cycle occupancy=0 and C is never delivered.
// - Halt: send X (halt=0) then H (halt=1) then Y -> X and H delivered, halt_done=1 after H. Y is never accepted; flush leaves halt_done=1.
// - WB mux (macro defined): head mem_rd=1, mem=16'hBEEF, alu=16'h1234 -> wb_data=16'hBEEF; mem_rd=0 -> 16'h1234. Undefined build -> wb_data=0.

Source files
------------

// File: rtl/pipeline_mw_skid.sv
// MEM/WB stage register with valid/ready handshake, 2-entry skid buffer, flush and sticky halt.
// Optional writeback mux enabled by defining PIPELINE_MW_WBMUX_EN.
module pipeline_mw_skid #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wr_en,
   input  logic              in_mem_rd,
   input  logic              in_halt,
   input  logic [SEL_W-1:0]  in_wr_sel,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wr_en,
   output logic              out_mem_rd,
   output logic              out_halt,
   output logic [SEL_W-1:0]  out_wr_sel,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_mem,
   output logic [DATA_W-1:0] wb_data,
   output logic [1:0]        occupancy,
   output logic              halt_done
);

   localparam int unsigned PayW = 3 + SEL_W + 2 * DATA_W;

   logic [PayW-1:0] in_pay;
   logic [PayW-1:0] main_q, main_d;
   logic [PayW-1:0] skid_q, skid_d;
   logic            main_valid_q, main_valid_d;
   logic            skid_valid_q, skid_valid_d;
   logic            halt_done_q, halt_done_d;
   logic            in_xfer;
   logic            out_xfer;

   assign in_pay = {in_wr_en, in_mem_rd, in_halt, in_wr_sel, in_alu, in_mem};
   assign {out_wr_en, out_mem_rd, out_halt, out_wr_sel, out_alu, out_mem} = main_q;

   // in_ready depends only on state, never on out_ready.
   assign in_ready  = ~skid_valid_q & ~halt_done_q;
   assign out_valid = main_valid_q & ~halt_done_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign halt_done = halt_done_q;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

`ifdef PIPELINE_MW_WBMUX_EN
   assign wb_data = out_mem_rd ? out_mem : out_alu;
`else
   assign wb_data = '0;
`endif

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      // A HALT delivered in a flush cycle still counts; a flushed one never does.
      halt_done_d  = halt_done_q | (out_xfer & out_halt);

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (in_xfer) begin
            main_d       = in_pay;
            main_valid_d = 1'b1;
         end
      end else if (out_xfer) begin
         if (skid_valid_q) begin
            main_d = skid_q;
            if (in_xfer) begin
               skid_d = in_pay;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (in_xfer) begin
            main_d = in_pay;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_xfer) begin
         skid_d       = in_pay;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         halt_done_q  <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         halt_done_q  <= halt_done_d;
      end
   end

endmodule

// File: tb/tb_pipeline_mw_skid.sv
// Scoreboard bench for pipeline_mw_skid: the model is a queue of held entries plus a halt flag.
// Build with PIPELINE_MW_WBMUX_EN defined to exercise the writeback mux expectations.
module tb_pipeline_mw_skid;

   typedef struct packed {
      logic        wr_en;
      logic        mem_rd;
      logic        halt;
      logic [2:0]  sel;
      logic [15:0] alu;
      logic [15:0] mem;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_wr_en = 1'b0;
   logic        in_mem_rd = 1'b0;
   logic        in_halt = 1'b0;
   logic [2:0]  in_wr_sel = '0;
   logic [15:0] in_alu = '0;
   logic [15:0] in_mem = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_wr_en;
   logic        out_mem_rd;
   logic        out_halt;
   logic [2:0]  out_wr_sel;
   logic [15:0] out_alu;
   logic [15:0] out_mem;
   logic [15:0] wb_data;
   logic [1:0]  occupancy;
   logic        halt_done;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int delivered = 0;

   entry_t model_q[$];
   logic   halt_m = 1'b0;

   pipeline_mw_skid #(.DATA_W(16), .SEL_W(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wr_en(in_wr_en), .in_mem_rd(in_mem_rd), .in_halt(in_halt),
      .in_wr_sel(in_wr_sel), .in_alu(in_alu), .in_mem(in_mem),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd), .out_halt(out_halt),
      .out_wr_sel(out_wr_sel), .out_alu(out_alu), .out_mem(out_mem),
      .wb_data(wb_data), .occupancy(occupancy), .halt_done(halt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else pass_cnt++;
   endtask

   function automatic logic [15:0] exp_wb(input entry_t e);
`ifdef PIPELINE_MW_WBMUX_EN
      return e.mem_rd ? e.mem : e.alu;
`else
      return 16'h0000;
`endif
   endfunction

   // Monitor/scoreboard: compares at the falling edge, then advances the model across the next
   // rising edge (inputs only change just after rising edges).
   always @(negedge clk) begin
      entry_t head;
      entry_t inc;
      logic   exp_ready, exp_ov, do_in, do_out;
      if (!rst) begin
         model_q.delete();
         halt_m = 1'b0;
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_occupancy", 32'(occupancy), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_halt_done", 32'(halt_done), 32'd0);
         chk("rst_out_alu", 32'(out_alu), 32'd0);
         chk("rst_out_fields", {out_wr_en, out_mem_rd, out_halt, out_wr_sel, out_mem}, 32'd0);
         chk("rst_wb_data", 32'(wb_data), 32'd0);
      end else begin
         exp_ready = (model_q.size() < 2) && !halt_m;
         exp_ov    = (model_q.size() > 0) && !halt_m;
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         chk("occupancy", 32'(occupancy), 32'(model_q.size()));
         chk("halt_done", 32'(halt_done), 32'(halt_m));
         head = '0;
         if (exp_ov) begin
            head = model_q[0];
            chk("head_alu", 32'(out_alu), 32'(head.alu));
            chk("head_mem", 32'(out_mem), 32'(head.mem));
            chk("head_ctl", 32'({out_wr_en, out_mem_rd, out_halt, out_wr_sel}),
                32'({head.wr_en, head.mem_rd, head.halt, head.sel}));
            chk("wb_data", 32'(wb_data), 32'(exp_wb(head)));
         end
         do_out = exp_ov && out_ready;
         do_in  = in_valid && exp_ready;
         if (do_out) delivered++;
         if (do_out && head.halt) halt_m = 1'b1;
         if (flush) begin
            model_q.delete();
         end else begin
            if (do_out) void'(model_q.pop_front());
            if (do_in) begin
               inc = '{in_wr_en, in_mem_rd, in_halt, in_wr_sel, in_alu, in_mem};
               model_q.push_back(inc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input entry_t e);
      in_wr_en  = e.wr_en;
      in_mem_rd = e.mem_rd;
      in_halt   = e.halt;
      in_wr_sel = e.sel;
      in_alu    = e.alu;
      in_mem    = e.mem;
   endtask

   function automatic entry_t mk(input logic halt, input logic mem_rd,
                                 input logic [15:0] alu, input logic [15:0] mem);
      entry_t e;
      e.wr_en  = 1'b1;
      e.mem_rd = mem_rd;
      e.halt   = halt;
      e.sel    = alu[2:0];
      e.alu    = alu;
      e.mem    = mem;
      return e;
   endfunction

   function automatic entry_t rnd(input logic allow_halt);
      entry_t e;
      e.wr_en  = 1'($urandom);
      e.mem_rd = 1'($urandom);
      e.halt   = allow_halt && ($urandom_range(0, 23) == 0);
      e.sel    = 3'($urandom);
      e.alu    = 16'($urandom);
      e.mem    = 16'($urandom);
      return e;
   endfunction

   // Hold an entry until the stage accepts it, bounded.
   task automatic send(input entry_t e);
      logic acc = 1'b0;
      drive(e);
      in_valid = 1'b1;
      for (int i = 0; i < 30 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!acc) begin
         chk_cnt++;
         $display("FAIL send_timeout: got in_ready=0 for 30 cycles expected acceptance");
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      int wait_cnt;
      do_reset();

      // Streaming alu = 1..8
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(mk(1'b0, 1'b0, 16'(i), 16'(i + 100)));
      step();
      step();

      // Backpressure
      out_ready = 1'b0;
      send(mk(1'b0, 1'b0, 16'hAAAA, 16'h0001));
      send(mk(1'b0, 1'b1, 16'hBBBB, 16'h0002));
      step();
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // Flush with a full stage and an incoming entry
      out_ready = 1'b0;
      send(mk(1'b0, 1'b0, 16'h0A0A, 16'h0003));
      send(mk(1'b0, 1'b0, 16'h0B0B, 16'h0004));
      drive(mk(1'b0, 1'b0, 16'h0C0C, 16'h0005));
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // WB mux selection
      out_ready = 1'b0;
      send(mk(1'b0, 1'b1, 16'h1234, 16'hBEEF));
      step();
      out_ready = 1'b1;
      send(mk(1'b0, 1'b0, 16'h1234, 16'hBEEF));
      step();
      step();

      // Halt: X, H, then Y only after the halt is observed
      out_ready = 1'b1;
      send(mk(1'b0, 1'b0, 16'h00A1, 16'h0000));
      send(mk(1'b1, 1'b0, 16'h00B2, 16'h0000));
      wait_cnt = 0;
      while (!halt_done && wait_cnt < 20) begin
         step();
         wait_cnt++;
      end
      if (wait_cnt >= 20) begin
         chk_cnt++;
         $display("FAIL halt_timeout: got halt_done=0 expected 1 within 20 cycles");
      end
      drive(mk(1'b0, 1'b0, 16'h00C3, 16'h0000));
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      do_reset();

      // Randomised traffic with flushes, halts and mid-stream resets
      for (int cyc = 0; cyc < 2000; cyc++) begin
         drive(rnd(1'b1));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         if (cyc % 500 == 250 || halt_done) begin
            if (halt_done) for (int i = 0; i < 3; i++) step();
            rst = 1'b0;
            step();
            rst = 1'b1;
         end
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      if (delivered < 100) begin
         chk_cnt++;
         $display("FAIL delivered_count: got %0d expected at least 100", delivered);
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
